// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the fetch sequencer slice:
//   - fetch_state_t : fetch FSM state encoding (WAIT / REQ / HALTED)
//   - DEFAULT_RESET_PC, DEFAULT_TRAP_VEC : default PC values for reset and trap
//   - align_pc()    : clears the two low bits of a PC value
package cpu_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
// Bundles the instruction-memory request channel and the decode-side buffer channel.
//   imem_req/imem_addr   : fetch request and address (sequencer -> memory)
//   imem_ack/imem_rdata  : one-cycle completion pulse and returned word (memory -> sequencer)
//   if_valid/if_pc/if_instr : buffered instruction (sequencer -> decode)
//   if_ready             : decode accepts the buffer (decode -> sequencer)
// Modports: master = fetch sequencer side, slave = memory/decode side.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_ack, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_ack, imem_rdata, if_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer
// Single-entry valid/ready holding register between fetch and decode.
//   clk, rst_n          : clock, synchronous active-low reset
//   load                : capture load_pc/load_instr and mark the entry valid
//   load_pc, load_instr : PC and instruction word to capture
//   flush               : drop the held entry (redirect)
//   ready               : consumer takes the entry this cycle
//   valid               : entry is held
//   out_pc, out_instr   : held PC and instruction word
module fetch_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  input  logic        flush,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  // A load always wins: the sequencer only loads when the entry is already
  // empty or being taken, and never loads in a redirect cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
    end else if (load) begin
      valid     <= 1'b1;
      out_pc    <= load_pc;
      out_instr <= load_instr;
    end else if (flush || (valid && ready)) begin
      valid     <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Owns the program counter and issues one-at-a-time instruction fetches,
// holding each returned word in a single-entry buffer for decode.
//   clk, rst_n        : clock, synchronous active-low reset
//   redirect_valid    : one-cycle taken branch/jump pulse, target in redirect_target
//   trap_valid        : one-cycle pulse redirecting to TRAP_VEC (wins over redirect_valid)
//   halt              : level, stops launching new fetches
//   bus (master)      : imem req/addr/ack/rdata and decode if_valid/if_pc/if_instr/if_ready
//   pc_misaligned     : one-cycle pulse after a redirect whose target had [1:0]!=0
//   pc                : architectural next-fetch PC
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_target,
  input  logic                      trap_valid,
  input  logic                      halt,
  fetch_sequencer_if.master         bus,
  output logic                      pc_misaligned,
  output logic [31:0]               pc
);

  fetch_state_t state, state_next;
  logic         launch;
  logic         load;
  logic         drop;
  logic         redir;
  logic [31:0]  target;
  logic [31:0]  imem_addr_q;

  assign redir  = trap_valid || redirect_valid;
  assign target = align_pc(trap_valid ? TRAP_VEC : redirect_target);

  assign bus.imem_req  = (state == REQ);
  assign bus.imem_addr = imem_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WAIT;
    else        state <= state_next;
  end

  // An ack only delivers an instruction when no redirect made it stale,
  // either earlier in the transaction (drop) or in the ack cycle itself.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    load       = 1'b0;
    case (state)
      WAIT: begin
        if (halt) begin
          state_next = HALTED;
        end else if (!bus.if_valid || bus.if_ready) begin
          state_next = REQ;
          launch     = 1'b1;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          state_next = WAIT;
          load       = !drop && !redir;
        end
      end
      HALTED: begin
        if (!halt) state_next = WAIT;
      end
      default: state_next = WAIT;
    endcase
  end

  // A launch coinciding with a redirect fetches from the new target so the
  // request is never stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      imem_addr_q   <= '0;
      pc_misaligned <= 1'b0;
    end else begin
      if (redir)     pc <= target;
      else if (load) pc <= pc + 32'd4;
      if (launch)    imem_addr_q <= redir ? target : pc;
      pc_misaligned <= redirect_valid && !trap_valid && (redirect_target[1:0] != 2'b00);
    end
  end

  // Remembers that the outstanding request was overtaken by a redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else if (state == REQ) begin
      if (bus.imem_ack) drop <= 1'b0;
      else if (redir)   drop <= 1'b1;
    end else begin
      drop <= 1'b0;
    end
  end

  fetch_buffer u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_pc    (pc),
    .load_instr (bus.imem_rdata),
    .flush      (redir),
    .ready      (bus.if_ready),
    .valid      (bus.if_valid),
    .out_pc     (bus.if_pc),
    .out_instr  (bus.if_instr)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Directed bench for fetch_sequencer: sequential fetch, decode back-pressure,
// redirect during an open request, trap priority, misaligned redirect,
// halt during a request and PC wrap-around.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic        halt;
  logic        pc_misaligned;
  logic [31:0] pc;

  int total = 0;
  int bad   = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .halt            (halt),
    .bus             (bus),
    .pc_misaligned   (pc_misaligned),
    .pc              (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rt, input logic tv,
                               input logic h, input logic rdy);
    redirect_valid  = rv;
    redirect_target = rt;
    trap_valid      = tv;
    halt            = h;
    bus.if_ready    = rdy;
  endtask

  task automatic waitReq(input string tag, input int budget);
    int n = 0;
    while (!bus.imem_req && n < budget) begin
      step();
      n++;
    end
    checkOutput({tag, "_req_seen"}, {31'd0, bus.imem_req}, 32'd1);
  endtask

  task automatic doFetch(input string tag, input logic [31:0] addr, input logic [31:0] word);
    waitReq(tag, 8);
    checkOutput({tag, "_addr"}, bus.imem_addr, addr);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    checkOutput({tag, "_if_valid"}, {31'd0, bus.if_valid}, 32'd1);
    checkOutput({tag, "_if_pc"}, bus.if_pc, addr);
    checkOutput({tag, "_if_instr"}, bus.if_instr, word);
    checkOutput({tag, "_req_low"}, {31'd0, bus.imem_req}, 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();

    checkOutput("rst_req", {31'd0, bus.imem_req}, 32'd0);
    checkOutput("rst_addr", bus.imem_addr, 32'h0);
    checkOutput("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    checkOutput("rst_if_pc", bus.if_pc, 32'h0);
    checkOutput("rst_if_instr", bus.if_instr, 32'h0);
    checkOutput("rst_misaligned", {31'd0, pc_misaligned}, 32'd0);
    checkOutput("rst_pc", pc, 32'h0);

    // Sequential fetch with decode always ready.
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    doFetch("seq0", 32'h0000_0000, 32'h1111_0013);
    doFetch("seq1", 32'h0000_0004, 32'h2222_0013);
    doFetch("seq2", 32'h0000_0008, 32'h3333_0013);
    doFetch("seq3", 32'h0000_000C, 32'h4444_0013);
    checkOutput("seq_pc", pc, 32'h0000_0010);

    // Decode stalls: no new request, buffer held.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stall_req", {31'd0, bus.imem_req}, 32'd0);
      checkOutput("stall_valid", {31'd0, bus.if_valid}, 32'd1);
      checkOutput("stall_instr", bus.if_instr, 32'h4444_0013);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("unstall_req", {31'd0, bus.imem_req}, 32'd1);
    checkOutput("unstall_addr", bus.imem_addr, 32'h0000_0010);
    checkOutput("unstall_valid", {31'd0, bus.if_valid}, 32'd0);

    // Redirect while the request is open; the late word must be dropped.
    applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("redir_pc", pc, 32'h0000_0200);
    checkOutput("redir_misaligned", {31'd0, pc_misaligned}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("redir_req_held", {31'd0, bus.imem_req}, 32'd1);
    checkOutput("redir_addr_held", bus.imem_addr, 32'h0000_0010);
    step();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    checkOutput("drop_valid", {31'd0, bus.if_valid}, 32'd0);
    checkOutput("drop_req", {31'd0, bus.imem_req}, 32'd0);
    checkOutput("drop_pc", pc, 32'h0000_0200);
    doFetch("redir", 32'h0000_0200, 32'h5555_0013);

    // Trap and redirect in the same cycle: trap wins, no misaligned pulse.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h0000_0082, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("trap_pc", pc, 32'h0000_0100);
    checkOutput("trap_misaligned", {31'd0, pc_misaligned}, 32'd0);
    checkOutput("trap_flush", {31'd0, bus.if_valid}, 32'd0);
    checkOutput("trap_req", {31'd0, bus.imem_req}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    doFetch("trap", 32'h0000_0100, 32'h6666_0013);

    // Misaligned redirect target: aligned PC, one-cycle pulse.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h0000_0203, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("mis_pc", pc, 32'h0000_0200);
    checkOutput("mis_pulse_hi", {31'd0, pc_misaligned}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("mis_pulse_lo", {31'd0, pc_misaligned}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    doFetch("mis", 32'h0000_0200, 32'h7777_0013);

    // Halt during an open request: it completes, then no new request.
    step();
    checkOutput("halt_req_open", {31'd0, bus.imem_req}, 32'd1);
    checkOutput("halt_req_addr", bus.imem_addr, 32'h0000_0204);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step();
    checkOutput("halt_req_kept", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h8888_0013;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    checkOutput("halt_done_valid", {31'd0, bus.if_valid}, 32'd1);
    checkOutput("halt_done_instr", bus.if_instr, 32'h8888_0013);
    checkOutput("halt_done_pc", pc, 32'h0000_0208);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("halted_no_req", {31'd0, bus.imem_req}, 32'd0);
    end
    checkOutput("halted_pc", pc, 32'h0000_0208);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("unhalt_req", {31'd0, bus.imem_req}, 32'd0);
    doFetch("resume", 32'h0000_0208, 32'h9999_0013);

    // PC wrap-around at the top of the address space.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("top_pc", pc, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    doFetch("top", 32'hFFFF_FFFC, 32'hAAAA_0013);
    checkOutput("wrap_pc", pc, 32'h0000_0000);
    doFetch("wrap", 32'h0000_0000, 32'hBBBB_0013);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
